// File: rtl/slv_mux_fsm_if.sv
// Upstream request/ack bundle between the bus adapter and slv_mux_fsm.
// The adapter drives the master side; the access controller sits on slave.
interface slv_mux_fsm_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_FWD    = 2
) ();
    logic                  if_soft_rst;
    logic                  if_req_vld;
    logic                  if_wr_en;
    logic                  if_rd_en;
    logic                  dummy_acc;
    logic                  reg_acc;
    logic [NUM_FWD-1:0]    fwd_sel;
    logic                  if_ack_vld;
    logic                  if_err;
    logic [DATA_WIDTH-1:0] if_rd_data;

    modport master (
        output if_soft_rst, if_req_vld, if_wr_en, if_rd_en,
        output dummy_acc, reg_acc, fwd_sel,
        input  if_ack_vld, if_err, if_rd_data
    );

    modport slave (
        input  if_soft_rst, if_req_vld, if_wr_en, if_rd_en,
        input  dummy_acc, reg_acc, fwd_sel,
        output if_ack_vld, if_err, if_rd_data
    );
endinterface

// File: rtl/slv_mux_fsm.sv
// Slave access controller: routes one request to regs, dummy or a fwd channel.
// Define SLV_MUX_FSM_TIMEOUT_EN to build the wait-state timeout counter.
module slv_mux_fsm #(
    parameter int unsigned           DATA_WIDTH      = 32,
    parameter int unsigned           NUM_FWD         = 2,
    parameter logic [DATA_WIDTH-1:0] DUMMY_READ_DATA = '0,
    parameter int unsigned           TIMEOUT_CYCLES  = 256
) (
    input  logic                          clk,
    input  logic                          rst_n,
    slv_mux_fsm_if.slave                  up,
    input  logic [DATA_WIDTH-1:0]         reg_rd_data,
    input  logic                          reg_rd_data_vld,
    output logic [NUM_FWD-1:0]            fwd_req_vld,
    output logic                          fwd_wr_en,
    output logic                          fwd_rd_en,
    input  logic [NUM_FWD-1:0]            fwd_ack_vld,
    input  logic [NUM_FWD-1:0]            fwd_err,
    input  logic [NUM_FWD*DATA_WIDTH-1:0] fwd_rd_data,
    output logic                          busy,
    output logic                          timeout_evt
);
    localparam int unsigned IW = (NUM_FWD > 1) ? $clog2(NUM_FWD) : 1;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        REG_RD_WAIT = 3'd1,
        FWD_WAIT    = 3'd2,
        ACK_OK      = 3'd3,
        ACK_ERR     = 3'd4
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  wr_q, wr_d;
    logic                  keep_q, keep_d;
    logic                  fwd_wr_q, fwd_wr_d;
    logic                  fwd_rd_q, fwd_rd_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [NUM_FWD-1:0]    req_q, req_d;

    logic                  sel_one;
    logic [IW-1:0]         sel_idx;
    logic                  ch_ack;
    logic                  ch_err;
    logic [DATA_WIDTH-1:0] ch_data;
    logic                  cnt_end;

    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < NUM_FWD; i++) begin
            if (up.fwd_sel[i]) sel_idx = IW'(i);
        end
    end

    assign sel_one = $onehot(up.fwd_sel);
    assign ch_ack  = fwd_ack_vld[idx_q];
    assign ch_err  = fwd_err[idx_q];
    assign ch_data = fwd_rd_data[idx_q*DATA_WIDTH +: DATA_WIDTH];

`ifdef SLV_MUX_FSM_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tmo_q, tmo_d;
    logic          in_wait;

    assign cnt_end = (cnt_q == CNT_MAX);
    assign in_wait = (state_q == REG_RD_WAIT) || (state_q == FWD_WAIT);

    // Counter restarts whenever a wait state is freshly entered.
    always_comb begin
        cnt_d = '0;
        tmo_d = 1'b0;
        if (!up.if_soft_rst && in_wait) begin
            if (state_d == state_q) cnt_d = cnt_q + 1'b1;
            if (state_q == REG_RD_WAIT)
                tmo_d = cnt_end && !reg_rd_data_vld;
            else
                tmo_d = cnt_end && !ch_ack;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tmo_q <= tmo_d;
        end
    end

    assign timeout_evt = tmo_q;
`else
    assign cnt_end     = 1'b0;
    assign timeout_evt = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        wr_d     = wr_q;
        keep_d   = keep_q;
        fwd_wr_d = fwd_wr_q;
        fwd_rd_d = fwd_rd_q;
        idx_d    = idx_q;
        req_d    = '0;
        unique case (state_q)
            IDLE: begin
                if (up.if_req_vld && (up.if_wr_en || up.if_rd_en)) begin
                    wr_d   = up.if_wr_en;
                    data_d = '0;
                    keep_d = 1'b0;
                    if (up.dummy_acc) begin
                        state_d = ACK_ERR;
                    end else if (up.reg_acc) begin
                        if (up.if_wr_en) begin
                            state_d = ACK_OK;
                        end else if (reg_rd_data_vld) begin
                            data_d  = reg_rd_data;
                            state_d = ACK_OK;
                        end else begin
                            state_d = REG_RD_WAIT;
                        end
                    end else if (sel_one) begin
                        idx_d    = sel_idx;
                        fwd_wr_d = up.if_wr_en;
                        fwd_rd_d = !up.if_wr_en;
                        req_d    = up.fwd_sel;
                        state_d  = FWD_WAIT;
                    end else begin
                        state_d = ACK_ERR;
                    end
                end
            end
            REG_RD_WAIT: begin
                if (reg_rd_data_vld) begin
                    data_d  = reg_rd_data;
                    state_d = ACK_OK;
                end else if (cnt_end) begin
                    state_d = ACK_ERR;
                end
            end
            FWD_WAIT: begin
                if (ch_ack) begin
                    data_d  = wr_q ? '0 : ch_data;
                    keep_d  = ch_err;
                    state_d = ch_err ? ACK_ERR : ACK_OK;
                end else if (cnt_end) begin
                    state_d = ACK_ERR;
                end
            end
            ACK_OK, ACK_ERR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (up.if_soft_rst) begin
            state_d = IDLE;
            req_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            data_q   <= '0;
            wr_q     <= 1'b0;
            keep_q   <= 1'b0;
            fwd_wr_q <= 1'b0;
            fwd_rd_q <= 1'b0;
            idx_q    <= '0;
            req_q    <= '0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            wr_q     <= wr_d;
            keep_q   <= keep_d;
            fwd_wr_q <= fwd_wr_d;
            fwd_rd_q <= fwd_rd_d;
            idx_q    <= idx_d;
            req_q    <= req_d;
        end
    end

    // Error acks return dummy data unless a channel itself reported the error.
    always_comb begin
        up.if_rd_data = '0;
        if (!wr_q) begin
            if (state_q == ACK_OK)
                up.if_rd_data = data_q;
            else if (state_q == ACK_ERR)
                up.if_rd_data = keep_q ? data_q : DUMMY_READ_DATA;
        end
    end

    assign up.if_ack_vld = (state_q == ACK_OK) || (state_q == ACK_ERR);
    assign up.if_err     = (state_q == ACK_ERR);
    assign busy          = (state_q != IDLE);
    assign fwd_req_vld   = req_q;
    assign fwd_wr_en     = fwd_wr_q;
    assign fwd_rd_en     = fwd_rd_q;
endmodule

// File: doc/slv_mux_fsm.md
# slv_mux_fsm

Multi-target slave access controller for generated register blocks. It takes one upstream request at a time and routes it to one of three places: the local register file, a dummy (error) responder, or one of `NUM_FWD` downstream forwarding channels. It returns exactly one acknowledge per accepted request, with read data and error status, and can optionally abort hung accesses with a timeout. It sits between the bus-protocol adapter (APB/AXI-lite front end) and the register array / child slave ports.

## Interface
- `DATA_WIDTH`, 32, read/write data width.
- `NUM_FWD`, 2, number of forwarding channels (≥1).
- `DUMMY_READ_DATA`, 0, read data returned on any error ack.
- `TIMEOUT_CYCLES`, 256, wait-state limit (≥2); used only when the timeout feature is compiled in.

Ports (reset `rst_n`, asynchronous, active-low; clock `clk`):
- `clk` in 1 — clock.
- `rst_n` in 1 — asynchronous active-low reset.
- `if_soft_rst` in 1 — synchronous abort to IDLE.
- `if_req_vld` in 1 — single-cycle request pulse; sampled in IDLE only.
- `if_wr_en`, `if_rd_en` in 1 each — access type, valid with `if_req_vld`.
- `dummy_acc` in 1 — address hits an unmapped/dummy region.
- `reg_acc` in 1 — address hits the local register file.
- `reg_rd_data` in DATA_WIDTH, `reg_rd_data_vld` in 1 — local read return.
- `fwd_sel` in NUM_FWD — one-hot channel decode, valid with `if_req_vld`.
- `fwd_req_vld` out NUM_FWD — one-cycle request pulse to the selected channel.
- `fwd_wr_en`, `fwd_rd_en` out 1 each — latched access type.
- `fwd_ack_vld` in NUM_FWD, `fwd_err` in NUM_FWD, `fwd_rd_data` in NUM_FWD*DATA_WIDTH — channel responses; channel i data occupies bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `if_ack_vld` out 1, `if_err` out 1, `if_rd_data` out DATA_WIDTH — upstream response.
- `busy` out 1 — high whenever state ≠ IDLE.
- `timeout_evt` out 1 — one-cycle pulse when an access is aborted by timeout.

## Operation
- States: IDLE, REG_RD_WAIT, FWD_WAIT, ACK_OK, ACK_ERR.
- IDLE with `if_req_vld`:
  - The access is a write if `if_wr_en` is set, else a read if `if_rd_en` is set; write wins if both are set.
  - If neither `if_wr_en` nor `if_rd_en` is set, the request is ignored.
  - Target priority: `dummy_acc` > `reg_acc` > `fwd_sel`.
  - Dummy hit → ACK_ERR.
  - Register write → ACK_OK.
  - Register read with `reg_rd_data_vld` in the same cycle → capture data, go to ACK_OK; otherwise → REG_RD_WAIT.
  - Exactly one `fwd_sel` bit set → latch channel index and access type, pulse `fwd_req_vld[idx]` on the next cycle, go to FWD_WAIT.
  - `fwd_sel` zero or with more than one bit set (no target) → ACK_ERR.
- REG_RD_WAIT: on `reg_rd_data_vld`, capture `reg_rd_data`, go to ACK_OK.
- FWD_WAIT:
  - Only the latched channel's `fwd_ack_vld`, `fwd_err` and data are observed; all other channels are ignored.
  - On ack, capture data (reads only; writes capture 0) and go to ACK_OK, or to ACK_ERR if `fwd_err` is set.
  - For an error ack on a read, `if_rd_data` is the channel's data, not `DUMMY_READ_DATA`.
- ACK_OK / ACK_ERR:
  - `if_ack_vld`=1 for exactly one cycle, then IDLE.
  - `if_err`=1 in ACK_ERR only.
  - `if_rd_data` = captured data in ACK_OK; `DUMMY_READ_DATA` in ACK_ERR, except for a forwarded error ack as above.
  - `if_rd_data` is 0 for writes and in all other states.
- `if_req_vld` outside IDLE is ignored; the upstream adapter guarantees no overlap.
- `if_soft_rst` has priority over everything:
  - next state is IDLE and the counter clears;
  - no ack is issued for the aborted access;
  - no `fwd_req_vld` pulse is issued if the abort lands in the issue cycle.
- Unreachable state encodings → IDLE.

## Timing
- All outputs are registered or state-decoded; no combinational path from inputs to `if_*` outputs.
- Reset values: state IDLE; `if_ack_vld`, `if_err`, `fwd_req_vld`, `fwd_wr_en`, `fwd_rd_en`, `busy`, `timeout_evt` = 0; `if_rd_data` = 0.
- Latency, with the request in cycle 0:
  - Dummy hit, register write, or register read with immediate valid: ack in cycle 1.
  - Register read waiting: ack one cycle after `reg_rd_data_vld`.
  - Forwarded access: `fwd_req_vld` in cycle 1; channel ack at cycle k ≥ 1 gives `if_ack_vld` at k+1.
- Back-to-back: after an ack cycle, the next request is accepted in the following IDLE cycle. Minimum request spacing is 2 cycles.

## Configuration
- `SLV_MUX_FSM_TIMEOUT_EN` defined:
  - A wait counter clears on entry to REG_RD_WAIT or FWD_WAIT and increments every wait cycle.
  - At count `TIMEOUT_CYCLES-1` with no response, the next state is ACK_ERR and `timeout_evt` pulses in the ACK_ERR cycle.
  - A response arriving in the terminal-count cycle wins: normal ack, no timeout.
  - Counter width is `$clog2(TIMEOUT_CYCLES)`.
- Not defined:
  - No counter is built; the wait states are held indefinitely.
  - `timeout_evt` is tied to 0.

## Test plan
- Reset mid-FWD_WAIT → all outputs 0, state IDLE. A dummy write next gives `if_ack_vld`=1, `if_err`=1 in cycle 1.
- Register read with `reg_rd_data_vld`=0 for 3 cycles, then 1 with data 0xA5A5_0001 → one ack carrying 0xA5A5_0001, `if_err`=0.
- NUM_FWD=4, `fwd_sel`=4'b0100, read:
  - `fwd_req_vld`=4'b0100 in cycle 1;
  - a spurious `fwd_ack_vld[0]` is ignored;
  - `fwd_ack_vld[2]` with `fwd_err`=1 and data 0x1234 → `if_err`=1, `if_rd_data`=0x1234.
- `fwd_sel`=4'b0110 or 4'b0000 → ACK_ERR, `if_rd_data`=`DUMMY_READ_DATA`, and no `fwd_req_vld` pulse.
- With the macro and TIMEOUT_CYCLES=8, a forwarded write with no ack → `if_ack_vld`, `if_err` and `timeout_evt` all high 8 cycles after the wait begins. A repeat with the ack arriving on the terminal-count cycle → `if_err`=0 and no `timeout_evt`.
- `if_soft_rst` asserted in REG_RD_WAIT → IDLE next cycle, no ack. A subsequent register write is acknowledged normally.
